// File: rtl/filterbank_sequencer.sv
// Frame sequencer for the shared serial filterbank: sample handshake, delay-line shift,
// tap-pair MAC phases, accumulator control and dump. Define FB_SEQ_SYMMETRIC_EN for folded taps.
module filterbank_sequencer #(
    parameter int TAPS  = 119,
    parameter int IDX_W = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             overrun_clr,
    output logic             shift_en,
    output logic             acc_clear,
    output logic             acc_en,
    output logic [IDX_W-1:0] tap_sel,
    output logic             last_phase,
    output logic             dump,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

`ifdef FB_SEQ_SYMMETRIC_EN
    localparam int NPH = (TAPS + 1) / 2;
`else
    localparam int NPH = TAPS;
`endif
    localparam logic [IDX_W-1:0] PH_LAST = IDX_W'(NPH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MAC   = 2'd2,
        DUMP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ph_q, ph_d;
    logic             overrun_q, overrun_d;
    logic             strobe_ok;
    logic             accept;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            ph_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        overrun_d = overrun_q;

        // Strobes are decodes of the registered state, silenced while stalled or in reset.
        strobe_ok  = clk_enable && !reset;
        in_ready   = strobe_ok && (state_q == IDLE || state_q == DUMP);
        shift_en   = strobe_ok && (state_q == SHIFT);
        acc_clear  = shift_en;
        acc_en     = strobe_ok && (state_q == MAC);
        last_phase = acc_en && (ph_q == PH_LAST);
        dump       = strobe_ok && (state_q == DUMP);
        out_valid  = dump;
        busy       = !reset && (state_q != IDLE);
        overrun    = overrun_q;
        tap_sel    = ph_q;
        accept     = in_valid && in_ready;

        if (clk_enable) begin
            unique case (state_q)
                IDLE: begin
                    if (accept) state_d = SHIFT;
                end
                SHIFT: begin
                    state_d = MAC;
                    ph_d    = '0;
                end
                MAC: begin
                    if (ph_q == PH_LAST) begin
                        state_d = DUMP;
                        ph_d    = '0;
                    end else begin
                        ph_d = ph_q + 1'b1;
                    end
                end
                DUMP: begin
                    state_d = accept ? SHIFT : IDLE;
                end
                default: state_d = IDLE;
            endcase

            // A sample offered mid-frame is dropped; a same-edge set beats the clear.
            if (overrun_clr) overrun_d = 1'b0;
            if (in_valid && (state_q == SHIFT || state_q == MAC)) overrun_d = 1'b1;
        end
    end

endmodule
